// File: rtl/mvm_stream_lanes.sv
// ---------------------------------------------------------------------------
// mvm_stream_lanes
//
// Signed matrix-vector multiplier y = A*x with LANES parallel MAC lanes and
// valid/ready streaming on both the operand input and the result output.
// Lane l owns every row r with r mod LANES == l. Rows are processed in
// groups of LANES rows, one column per cycle per lane.
//
// Build option:
//   MVM_SAT_EN  defined     -> out_data saturates to the OUTW signed range
//               not defined -> out_data is the low OUTW bits of the sum
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   load_matrix  one-cycle command: stream ROWS*COLS words, row-major
//   load_vector  one-cycle command: stream COLS words
//   start        one-cycle command: compute y (needs both operands loaded)
//   in_valid     in_data valid
//   in_ready     block accepts in_data (only while loading)
//   in_data      signed B-bit operand word
//   out_valid    out_data valid
//   out_ready    downstream accepts out_data
//   out_data     signed OUTW-bit y element, rows 0..ROWS-1 in order
//   busy         high whenever not IDLE
//   done         one-cycle pulse after the last y element is accepted
// ---------------------------------------------------------------------------
module mvm_stream_lanes #(
   parameter int ROWS  = 8,
   parameter int COLS  = 8,
   parameter int LANES = 2,
   parameter int B     = 8,
   parameter int ACCW  = 2*B + $clog2(COLS),
   parameter int OUTW  = 2*B
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load_matrix,
   input  logic                   load_vector,
   input  logic                   start,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [B-1:0]    in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [OUTW-1:0] out_data,
   output logic                   busy,
   output logic                   done
);

   localparam int GROUPS = ROWS / LANES;
   localparam int MWORDS = ROWS * COLS;
   localparam int ISSUE  = GROUPS * COLS;   // multiply-issue cycles
   localparam int TOTAL  = ISSUE + 2;       // plus product and accumulate stages
   localparam int MAIW   = (MWORDS > 1) ? $clog2(MWORDS) : 1;
   localparam int CW     = (COLS   > 1) ? $clog2(COLS)   : 1;
   localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam int LW     = (LANES  > 1) ? $clog2(LANES)  : 1;
   localparam int TW     = $clog2(TOTAL);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_M,
      ST_LOAD_V,
      ST_COMPUTE,
      ST_DRAIN
   } state_t;

   state_t          state_q, state_d;
   logic [MAIW-1:0] ld_cnt_q, ld_cnt_d;
   logic [CW-1:0]   col_q, col_d;
   logic [GW-1:0]   grp_q, grp_d;
   logic [TW-1:0]   cnt_q, cnt_d;
   logic [LW-1:0]   dr_lane_q, dr_lane_d;
   logic [GW-1:0]   dr_grp_q, dr_grp_d;
   logic            mat_ok_q, mat_ok_d;
   logic            vec_ok_q, vec_ok_d;
   logic            done_q, done_d;
   logic            issue;
   logic            mat_we;
   logic            vec_we;

   // Operand storage; contents survive reset, only the *_ok flags are cleared.
   logic signed [B-1:0] mat_mem [MWORDS];
   logic signed [B-1:0] vec_mem [COLS];

   // Pipeline control shared by all lanes (lanes run in lock-step).
   logic            p_vld_q, p_first_q, p_last_q;
   logic [GW-1:0]   p_grp_q;
   logic            a_last_q;
   logic [GW-1:0]   a_grp_q;

   logic [LANES-1:0][ACCW-1:0] lane_rd;
   logic signed [ACCW-1:0]     sel_acc;
   logic signed [OUTW-1:0]     res_val;

   // ------------------------------------------------------------------------
   // State and control registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         ld_cnt_q  <= '0;
         col_q     <= '0;
         grp_q     <= '0;
         cnt_q     <= '0;
         dr_lane_q <= '0;
         dr_grp_q  <= '0;
         mat_ok_q  <= 1'b0;
         vec_ok_q  <= 1'b0;
         done_q    <= 1'b0;
         p_vld_q   <= 1'b0;
         p_first_q <= 1'b0;
         p_last_q  <= 1'b0;
         p_grp_q   <= '0;
         a_last_q  <= 1'b0;
         a_grp_q   <= '0;
      end else begin
         state_q   <= state_d;
         ld_cnt_q  <= ld_cnt_d;
         col_q     <= col_d;
         grp_q     <= grp_d;
         cnt_q     <= cnt_d;
         dr_lane_q <= dr_lane_d;
         dr_grp_q  <= dr_grp_d;
         mat_ok_q  <= mat_ok_d;
         vec_ok_q  <= vec_ok_d;
         done_q    <= done_d;
         p_vld_q   <= issue;
         p_first_q <= (col_q == '0);
         p_last_q  <= (col_q == CW'(COLS-1));
         p_grp_q   <= grp_q;
         // Sum of a group is complete one cycle after its last product lands.
         a_last_q  <= p_vld_q & p_last_q;
         a_grp_q   <= p_grp_q;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      ld_cnt_d  = ld_cnt_q;
      col_d     = col_q;
      grp_d     = grp_q;
      cnt_d     = cnt_q;
      dr_lane_d = dr_lane_q;
      dr_grp_d  = dr_grp_q;
      mat_ok_d  = mat_ok_q;
      vec_ok_d  = vec_ok_q;
      done_d    = 1'b0;
      issue     = 1'b0;
      mat_we    = 1'b0;
      vec_we    = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (load_matrix) begin
               state_d  = ST_LOAD_M;
               ld_cnt_d = '0;
               mat_ok_d = 1'b0;   // a partial load must not be computed on
            end else if (load_vector) begin
               state_d  = ST_LOAD_V;
               ld_cnt_d = '0;
               vec_ok_d = 1'b0;
            end else if (start && mat_ok_q && vec_ok_q) begin
               state_d = ST_COMPUTE;
               col_d   = '0;
               grp_d   = '0;
               cnt_d   = '0;
            end
         end

         ST_LOAD_M: begin
            in_ready = 1'b1;
            if (in_valid) begin
               mat_we = 1'b1;
               if (ld_cnt_q == MAIW'(MWORDS-1)) begin
                  mat_ok_d = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  ld_cnt_d = ld_cnt_q + MAIW'(1);
               end
            end
         end

         ST_LOAD_V: begin
            in_ready = 1'b1;
            if (in_valid) begin
               vec_we = 1'b1;
               if (ld_cnt_q == MAIW'(COLS-1)) begin
                  vec_ok_d = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  ld_cnt_d = ld_cnt_q + MAIW'(1);
               end
            end
         end

         ST_COMPUTE: begin
            cnt_d = cnt_q + TW'(1);
            if (cnt_q < TW'(ISSUE)) begin
               issue = 1'b1;
               if (col_q == CW'(COLS-1)) begin
                  col_d = '0;
                  grp_d = grp_q + GW'(1);
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
            // The last two cycles only flush the product and accumulate stages.
            if (cnt_q == TW'(TOTAL-1)) begin
               state_d   = ST_DRAIN;
               dr_lane_d = '0;
               dr_grp_d  = '0;
            end
         end

         ST_DRAIN: begin
            out_valid = 1'b1;
            if (out_ready) begin
               // Row = grp*LANES + lane, so the lane index runs fastest.
               if (dr_lane_q == LW'(LANES-1)) begin
                  dr_lane_d = '0;
                  if (dr_grp_q == GW'(GROUPS-1)) begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     dr_grp_d = dr_grp_q + GW'(1);
                  end
               end else begin
                  dr_lane_d = dr_lane_q + LW'(1);
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;

   // ------------------------------------------------------------------------
   // Operand storage writes
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (mat_we) mat_mem[ld_cnt_q] <= in_data;
      if (vec_we) vec_mem[ld_cnt_q[CW-1:0]] <= in_data;
   end

   // ------------------------------------------------------------------------
   // MAC lanes
   // ------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [MAIW-1:0]        a_addr;
         logic signed [2*B-1:0]  prod;
         logic signed [2*B-1:0]  p_q;
         logic signed [ACCW-1:0] acc_q;
         logic signed [ACCW-1:0] acc_base;
         logic signed [ACCW-1:0] y_buf [GROUPS];

         assign a_addr   = MAIW'((int'(grp_q) * LANES + gi) * COLS + int'(col_q));
         assign prod     = mat_mem[a_addr] * vec_mem[col_q];
         // First column of a group starts a fresh sum.
         assign acc_base = p_first_q ? '0 : acc_q;

         always_ff @(posedge clk) begin
            if (issue)    p_q <= prod;
            if (p_vld_q)  acc_q <= acc_base + ACCW'(p_q);
            if (a_last_q) y_buf[a_grp_q] <= acc_q;
         end

         assign lane_rd[gi] = y_buf[dr_grp_q];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Result formatting
   // ------------------------------------------------------------------------
   assign sel_acc = $signed(lane_rd[dr_lane_q]);

`ifdef MVM_SAT_EN
   localparam logic signed [ACCW-1:0] SAT_HI = ACCW'((64'sd1 <<< (OUTW-1)) - 64'sd1);
   localparam logic signed [ACCW-1:0] SAT_LO = ACCW'(-(64'sd1 <<< (OUTW-1)));

   always_comb begin
      res_val = sel_acc[OUTW-1:0];
      if (sel_acc > SAT_HI)      res_val = SAT_HI[OUTW-1:0];
      else if (sel_acc < SAT_LO) res_val = SAT_LO[OUTW-1:0];
   end
`else
   logic unused_acc_hi;

   // Two's-complement wrap: the upper accumulator bits are simply dropped.
   assign res_val       = sel_acc[OUTW-1:0];
   assign unused_acc_hi = ^sel_acc[ACCW-1:OUTW];
`endif

   assign out_data = out_valid ? res_val : '0;

endmodule

// File: tb/tb_mvm_stream_lanes.sv
module tb_mvm_stream_lanes;
   localparam int ROWS  = 8;
   localparam int COLS  = 8;
   localparam int LANES = 2;
   localparam int B     = 8;
   localparam int OUTW  = 16;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   load_matrix;
   logic                   load_vector;
   logic                   start;
   logic                   in_valid;
   logic                   in_ready;
   logic signed [B-1:0]    in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic signed [OUTW-1:0] out_data;
   logic                   busy;
   logic                   done;

   always #5 clk = ~clk;

   mvm_stream_lanes #(.ROWS(ROWS), .COLS(COLS), .LANES(LANES), .B(B)) dut (
      .clk         (clk),
      .reset       (reset),
      .load_matrix (load_matrix),
      .load_vector (load_vector),
      .start       (start),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .busy        (busy),
      .done        (done)
   );

   int errors = 0;
   int checks = 0;

   int A [ROWS*COLS];
   int X [COLS];

   logic signed [OUTW-1:0] got_q [$];
   int lat, ndone, done_early, timeout, hold_bad;

   // Behavioural reference: plain integer dot product, then wrap or clamp.
   function automatic logic signed [OUTW-1:0] ref_y(input int r);
      longint s = 0;
      logic signed [63:0] s64;
      for (int c = 0; c < COLS; c++) s += longint'(A[r*COLS+c]) * longint'(X[c]);
`ifdef MVM_SAT_EN
      if (s > (longint'(1) <<< (OUTW-1)) - 1) s = (longint'(1) <<< (OUTW-1)) - 1;
      else if (s < -(longint'(1) <<< (OUTW-1))) s = -(longint'(1) <<< (OUTW-1));
`endif
      s64 = s;
      return s64[OUTW-1:0];
   endfunction

   task automatic set_identity();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) A[r*COLS+c] = (r == c) ? 1 : 0;
   endtask

   // Issue a load command and stream the words; optionally idle every other cycle.
   task automatic load_words(input bit is_mat, input bit gapped,
                             output bit rdy_ok, output bit busy_mid, output bit busy_end);
      int n;
      n = is_mat ? ROWS*COLS : COLS;
      rdy_ok   = 1'b1;
      busy_mid = 1'b0;
      @(negedge clk);
      if (is_mat) load_matrix = 1'b1; else load_vector = 1'b1;
      @(negedge clk);
      load_matrix = 1'b0;
      load_vector = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (gapped) begin
            in_valid = 1'b0;
            in_data  = 8'sh55;
            @(negedge clk);
         end
         if (i == n-1) busy_mid = busy;
         in_valid = 1'b1;
         in_data  = is_mat ? B'(A[i]) : B'(X[i]);
         if (in_ready !== 1'b1) rdy_ok = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b0;
      busy_end = busy;
   endtask

   task automatic load_both();
      bit a, b, c;
      load_words(1'b1, 1'b0, a, b, c);
      load_words(1'b0, 1'b0, a, b, c);
   endtask

   task automatic pulse_start_watch(output bit saw);
      saw = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (busy || out_valid) saw = 1'b1;
         @(negedge clk);
      end
   endtask

   // Start a compute and collect the drained rows. lat = rising edges from the
   // edge that samples start until out_valid is first seen.
   task automatic run_compute(input int stall_row, input int stall_len, input bit rnd_ready);
      int edges = 0;
      int post = 0;
      int stall_left;
      logic signed [OUTW-1:0] held;
      bit held_set = 1'b0;
      stall_left = stall_len;
      held = '0;
      got_q.delete();
      lat = -1; ndone = 0; done_early = 0; timeout = 0; hold_bad = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      while (1) begin
         if (done) begin
            ndone++;
            if (got_q.size() < ROWS) done_early++;
         end
         if (out_valid && lat < 0) lat = edges;
         out_ready = 1'b1;
         if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
         if (out_valid && got_q.size() == stall_row && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
            if (!held_set) begin
               held = out_data;
               held_set = 1'b1;
            end else if (out_data !== held) hold_bad++;
         end
         if (out_valid && out_ready) begin
            if (held_set && got_q.size() == stall_row && out_data !== held) hold_bad++;
            got_q.push_back(out_data);
         end
         if (got_q.size() >= ROWS) post++;
         if (post > 3) break;
         if (edges > 1000) begin
            timeout = 1;
            break;
         end
         @(negedge clk);
         edges++;
      end
      out_ready = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, out_valid, done, in_ready} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl: busy/out_valid/done/in_ready=%b expected 0000",
                  {busy, out_valid, done, in_ready});
      end
      checks++;
      if (out_data !== '0) begin
         errors++;
         $display("FAIL reset_data: out_data=%0d expected 0", out_data);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_start_ignored();
      bit saw, a, b, c;
      pulse_start_watch(saw);
      checks++;
      if (saw !== 1'b0) begin
         errors++;
         $display("FAIL start_no_operands: activity=%0d expected 0", saw);
      end
      set_identity();
      load_words(1'b1, 1'b0, a, b, c);
      pulse_start_watch(saw);
      checks++;
      if (saw !== 1'b0) begin
         errors++;
         $display("FAIL start_matrix_only: activity=%0d expected 0", saw);
      end
   endtask

   task automatic test_identity();
      set_identity();
      for (int c = 0; c < COLS; c++) X[c] = c + 1;
      load_both();
      run_compute(-1, 0, 1'b0);
      checks++;
      if (timeout != 0) begin errors++; $display("FAIL ident_timeout: timeout=%0d expected 0", timeout); end
      checks++;
      if (lat != 34) begin errors++; $display("FAIL ident_latency: got %0d expected 34", lat); end
      checks++;
      if (ndone != 1 || done_early != 0) begin
         errors++;
         $display("FAIL ident_done: pulses=%0d early=%0d expected 1/0", ndone, done_early);
      end
      checks++;
      if (got_q.size() != ROWS) begin
         errors++;
         $display("FAIL ident_count: rows=%0d expected %0d", got_q.size(), ROWS);
      end
      for (int r = 0; r < ROWS && r < got_q.size(); r++) begin
         checks++;
         if (got_q[r] !== OUTW'(r + 1)) begin
            errors++;
            $display("FAIL ident_y%0d: got %0d expected %0d", r, got_q[r], r + 1);
         end
      end
   endtask

   task automatic test_overflow();
      logic signed [OUTW-1:0] exp_y;
`ifdef MVM_SAT_EN
      exp_y = 16'sd32767;
`else
      exp_y = 16'sd0;
`endif
      for (int i = 0; i < ROWS*COLS; i++) A[i] = -128;
      for (int c = 0; c < COLS; c++) X[c] = -128;
      load_both();
      run_compute(-1, 0, 1'b0);
      checks++;
      if (got_q.size() != ROWS || timeout != 0) begin
         errors++;
         $display("FAIL ovf_count: rows=%0d timeout=%0d expected %0d/0", got_q.size(), timeout, ROWS);
      end
      for (int r = 0; r < ROWS && r < got_q.size(); r++) begin
         checks++;
         if (got_q[r] !== exp_y) begin
            errors++;
            $display("FAIL ovf_y%0d: got %0d expected %0d", r, got_q[r], exp_y);
         end
      end
   endtask

   task automatic test_gapped_load();
      bit rdy_ok, busy_mid, busy_end, a, b, c;
      set_identity();
      load_words(1'b1, 1'b1, rdy_ok, busy_mid, busy_end);
      checks++;
      if (rdy_ok !== 1'b1) begin errors++; $display("FAIL gap_in_ready: ok=%0d expected 1", rdy_ok); end
      checks++;
      if (busy_mid !== 1'b1 || busy_end !== 1'b0) begin
         errors++;
         $display("FAIL gap_word_count: busy before/after word 64 = %0d/%0d expected 1/0", busy_mid, busy_end);
      end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL gap_idle_ready: in_ready=%0d expected 0", in_ready); end
      for (int c2 = 0; c2 < COLS; c2++) X[c2] = c2 + 1;
      load_words(1'b0, 1'b0, a, b, c);
      run_compute(-1, 0, 1'b0);
      checks++;
      if (got_q.size() != ROWS || timeout != 0) begin
         errors++;
         $display("FAIL gap_count: rows=%0d timeout=%0d expected %0d/0", got_q.size(), timeout, ROWS);
      end
      for (int r = 0; r < ROWS && r < got_q.size(); r++) begin
         checks++;
         if (got_q[r] !== OUTW'(r + 1)) begin
            errors++;
            $display("FAIL gap_y%0d: got %0d expected %0d", r, got_q[r], r + 1);
         end
      end
   endtask

   task automatic test_backpressure();
      // Operands left over from the previous test: identity A, x = 1..8.
      run_compute(3, 5, 1'b0);
      checks++;
      if (hold_bad != 0) begin errors++; $display("FAIL bp_hold: changes=%0d expected 0", hold_bad); end
      checks++;
      if (ndone != 1 || done_early != 0) begin
         errors++;
         $display("FAIL bp_done: pulses=%0d early=%0d expected 1/0", ndone, done_early);
      end
      checks++;
      if (got_q.size() != ROWS || timeout != 0) begin
         errors++;
         $display("FAIL bp_count: rows=%0d timeout=%0d expected %0d/0", got_q.size(), timeout, ROWS);
      end
      for (int r = 0; r < ROWS && r < got_q.size(); r++) begin
         checks++;
         if (got_q[r] !== ref_y(r)) begin
            errors++;
            $display("FAIL bp_y%0d: got %0d expected %0d", r, got_q[r], ref_y(r));
         end
      end
   endtask

   task automatic test_random();
      bit a, b, c;
      for (int it = 0; it < 4; it++) begin
         // Alternate which operand is reloaded to exercise operand reuse.
         if (it != 2) begin
            for (int i = 0; i < ROWS*COLS; i++) A[i] = $urandom_range(0, 255) - 128;
            load_words(1'b1, 1'b0, a, b, c);
         end
         if (it != 1) begin
            for (int i = 0; i < COLS; i++) X[i] = $urandom_range(0, 255) - 128;
            load_words(1'b0, 1'b0, a, b, c);
         end
         run_compute(-1, 0, 1'b1);
         checks++;
         if (got_q.size() != ROWS || timeout != 0 || ndone != 1) begin
            errors++;
            $display("FAIL rnd%0d_count: rows=%0d timeout=%0d done=%0d expected %0d/0/1",
                     it, got_q.size(), timeout, ndone, ROWS);
         end
         for (int r = 0; r < ROWS && r < got_q.size(); r++) begin
            checks++;
            if (got_q[r] !== ref_y(r)) begin
               errors++;
               $display("FAIL rnd%0d_y%0d: got %0d expected %0d", it, r, got_q[r], ref_y(r));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit saw, a, b, c;
      bit seen_valid = 1'b0;
      set_identity();
      for (int i = 0; i < COLS; i++) X[i] = i + 3;
      load_both();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (12) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, out_valid, done, in_ready} !== 4'b0000 || out_data !== '0) begin
         errors++;
         $display("FAIL midrst_outputs: ctrl=%b data=%0d expected 0000/0",
                  {busy, out_valid, done, in_ready}, out_data);
      end
      reset = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) seen_valid = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (seen_valid !== 1'b0) begin errors++; $display("FAIL midrst_partial: out_valid seen=%0d expected 0", seen_valid); end
      pulse_start_watch(saw);
      checks++;
      if (saw !== 1'b0) begin errors++; $display("FAIL midrst_start_none: activity=%0d expected 0", saw); end
      for (int i = 0; i < COLS; i++) X[i] = 2;
      load_words(1'b0, 1'b0, a, b, c);
      pulse_start_watch(saw);
      checks++;
      if (saw !== 1'b0) begin errors++; $display("FAIL midrst_start_vec: activity=%0d expected 0", saw); end
      load_words(1'b1, 1'b0, a, b, c);
      run_compute(-1, 0, 1'b0);
      checks++;
      if (got_q.size() != ROWS || timeout != 0) begin
         errors++;
         $display("FAIL midrst_count: rows=%0d timeout=%0d expected %0d/0", got_q.size(), timeout, ROWS);
      end
      for (int r = 0; r < ROWS && r < got_q.size(); r++) begin
         checks++;
         if (got_q[r] !== 16'sd2) begin
            errors++;
            $display("FAIL midrst_y%0d: got %0d expected 2", r, got_q[r]);
         end
      end
   endtask

   initial begin
      reset = 1'b1; load_matrix = 1'b0; load_vector = 1'b0; start = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      test_reset();
      test_start_ignored();
      test_identity();
      test_overflow();
      test_gapped_load();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
